// File: rtl/e203_disp_pkg.sv
// Shared constants for the EXU dispatch buffer: decode group codes, FSM state
// encoding and default parameter values.
package e203_disp_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int DEPTH_DEF   = 2;
  localparam int ITAG_W_DEF  = 1;
  localparam int RFIDX_W_DEF = 5;

  localparam logic [2:0] GRP_ALU = 3'd0;
  localparam logic [2:0] GRP_BJP = 3'd1;
  localparam logic [2:0] GRP_AGU = 3'd2;
  localparam logic [2:0] GRP_CSR = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HPEND = 2'd2,
    ST_HALT  = 2'd3
  } disp_state_e;

  // CSR accesses and fences must see an idle OITF before they issue.
  function automatic logic is_serial(input logic [2:0] grp, input logic fence);
    return (grp == GRP_CSR) || ((grp == GRP_BJP) && fence);
  endfunction

endpackage

// File: rtl/e203_exu_disp_buf_if.sv
// Decoded-instruction push side and ALU issue side of the dispatch buffer.
interface e203_exu_disp_buf_if
  import e203_disp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RFIDX_W = RFIDX_W_DEF,
  parameter int ITAG_W  = ITAG_W_DEF
);
  logic               i_valid;
  logic               i_ready;
  logic               i_rs1en;
  logic               i_rs2en;
  logic               i_rdwen;
  logic               i_rs1x0;
  logic               i_rs2x0;
  logic [RFIDX_W-1:0] i_rs1idx;
  logic [RFIDX_W-1:0] i_rs2idx;
  logic [RFIDX_W-1:0] i_rdidx;
  logic [XLEN-1:0]    i_rs1;
  logic [XLEN-1:0]    i_rs2;
  logic [XLEN-1:0]    i_pc;
  logic [2:0]         i_grp;
  logic               i_fence;

  logic               o_valid;
  logic               o_ready;
  logic               o_longpipe;
  logic [XLEN-1:0]    o_rs1;
  logic [XLEN-1:0]    o_rs2;
  logic [XLEN-1:0]    o_pc;
  logic [RFIDX_W-1:0] o_rdidx;
  logic               o_rdwen;
  logic [2:0]         o_grp;
  logic [ITAG_W-1:0]  o_itag;

  modport master (
    output i_valid, i_rs1en, i_rs2en, i_rdwen, i_rs1x0, i_rs2x0,
           i_rs1idx, i_rs2idx, i_rdidx, i_rs1, i_rs2, i_pc, i_grp, i_fence,
    input  i_ready,
    input  o_valid, o_rs1, o_rs2, o_pc, o_rdidx, o_rdwen, o_grp, o_itag,
    output o_ready, o_longpipe
  );

  modport slave (
    input  i_valid, i_rs1en, i_rs2en, i_rdwen, i_rs1x0, i_rs2x0,
           i_rs1idx, i_rs2idx, i_rdidx, i_rs1, i_rs2, i_pc, i_grp, i_fence,
    output i_ready,
    output o_valid, o_rs1, o_rs2, o_pc, o_rdidx, o_rdwen, o_grp, o_itag,
    input  o_ready, o_longpipe
  );
endinterface

// File: rtl/e203_disp_fifo.sv
// Flat-word FIFO with wrap-around pointers; head word is read combinationally.
module e203_disp_fifo
  import e203_disp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
endmodule

// File: rtl/e203_exu_disp_buf.sv
// Dispatch buffer between decode and ALU issue: FIFO of decoded instructions,
// OITF-aware issue qualification, WFI halt handshake and a stall counter.
module e203_exu_disp_buf
  import e203_disp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ITAG_W  = ITAG_W_DEF,
  parameter int RFIDX_W = RFIDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  e203_exu_disp_buf_if.slave bus,
  output logic               h_rs1en,
  output logic               h_rs2en,
  output logic               h_rdwen,
  output logic [RFIDX_W-1:0] h_rs1idx,
  output logic [RFIDX_W-1:0] h_rs2idx,
  output logic [RFIDX_W-1:0] h_rdidx,
  input  logic               dep,
  input  logic               oitf_empty,
  input  logic               oitf_ready,
  input  logic [ITAG_W-1:0]  oitf_ptr,
  output logic               oitf_ena,
  input  logic               wfi_halt_req,
  output logic               wfi_halt_ack,
  input  logic               amo_wait,
  output logic [15:0]        stall_cnt
);
  localparam int EW = 3*XLEN + 3*RFIDX_W + 7;

  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] rs1_w;
  logic [XLEN-1:0] rs2_w;
  logic [XLEN-1:0] head_rs1;
  logic [XLEN-1:0] head_rs2;
  logic [XLEN-1:0] head_pc;
  logic [2:0]      head_grp;
  logic            head_fence;
  logic            head_serial;
  logic            head_longp;
  disp_state_e     state;
  disp_state_e     state_nxt;

  // x0 sources are stored as zero so the ALU never sees stale operand data.
  assign rs1_w = bus.i_rs1x0 ? '0 : bus.i_rs1;
  assign rs2_w = bus.i_rs2x0 ? '0 : bus.i_rs2;
  assign wdata = {bus.i_rs1en, bus.i_rs2en, bus.i_rdwen, bus.i_rs1idx,
                  bus.i_rs2idx, bus.i_rdidx, rs1_w, rs2_w, bus.i_pc,
                  bus.i_grp, bus.i_fence};

  e203_disp_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .empty (empty),
    .full  (full)
  );

  assign {h_rs1en, h_rs2en, h_rdwen, h_rs1idx, h_rs2idx, h_rdidx,
          head_rs1, head_rs2, head_pc, head_grp, head_fence} = rdata;

  assign head_serial = !empty && is_serial(head_grp, head_fence);
  assign head_longp  = !empty && (head_grp == GRP_AGU);

  assign bus.i_ready = !full;
  assign bus.o_valid = !empty && (state == ST_RUN) && !dep &&
                       !(head_serial && !oitf_empty) &&
                       !(head_longp && !oitf_ready);
  assign bus.o_rs1   = head_rs1;
  assign bus.o_rs2   = head_rs2;
  assign bus.o_pc    = head_pc;
  assign bus.o_rdidx = h_rdidx;
  assign bus.o_rdwen = h_rdwen;
  assign bus.o_grp   = head_grp;
  assign bus.o_itag  = oitf_ptr;

  assign push     = bus.i_valid && bus.i_ready;
  assign pop      = bus.o_valid && bus.o_ready;
  assign oitf_ena = pop && bus.o_longpipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      wfi_halt_ack <= 1'b0;
    end else begin
      state        <= state_nxt;
      wfi_halt_ack <= (state_nxt == ST_HALT);
    end
  end

  // A pending WFI request outranks draining for a serialising head.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (wfi_halt_req && !pop)            state_nxt = ST_HPEND;
        else if (head_serial && !oitf_empty) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wfi_halt_req)    state_nxt = ST_HPEND;
        else if (oitf_empty) state_nxt = ST_RUN;
      end
      ST_HPEND: begin
        if (!wfi_halt_req)                 state_nxt = ST_RUN;
        else if (oitf_empty && !amo_wait)  state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (!wfi_halt_req) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!empty && !pop && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: doc/e203_exu_disp_buf.md
E203_EXU_DISP_BUF -- requirements
Module: e203_exu_disp_buf

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width; DEPTH, default 2, dispatch-buffer entries (power of 2, >=2); ITAG_W, default 1, OITF pointer width; RFIDX_W, default 5, register index width.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 i_valid in 1, i_ready out 1: decoded-instruction push handshake.
REQ-004 i_rs1en/i_rs2en/i_rdwen in 1 each; i_rs1x0/i_rs2x0 in 1 each: source index is x0.
REQ-005 i_rs1idx/i_rs2idx/i_rdidx in RFIDX_W; i_rs1/i_rs2/i_pc in XLEN; i_grp in 3: decode group; i_fence in 1: fence/fence.i.
REQ-006 o_valid out 1, o_ready in 1, o_longpipe in 1: ALU issue handshake; o_longpipe is valid with o_valid.
REQ-007 o_rs1/o_rs2/o_pc out XLEN; o_rdidx out RFIDX_W; o_rdwen out 1; o_grp out 3; o_itag out ITAG_W.
REQ-008 h_rs1en/h_rs2en/h_rdwen out 1; h_rs1idx/h_rs2idx/h_rdidx out RFIDX_W: buffer head to OITF matcher.
REQ-009 dep in 1: OITF reports RAW/WAW match against head; oitf_empty/oitf_ready in 1; oitf_ptr in ITAG_W; oitf_ena out 1.
REQ-010 wfi_halt_req in 1, wfi_halt_ack out 1, amo_wait in 1; stall_cnt out 16.

Function
REQ-011 Buffer SHALL be a DEPTH-entry FIFO with wrap-around pointers and count 0..DEPTH; i_ready = (count != DEPTH).
REQ-012 Push (i_valid & i_ready) and pop (o_valid & o_ready) in the same cycle SHALL leave count unchanged, also at count = DEPTH-1 and count = 1.
REQ-013 Entry storage SHALL write o_rs1 = 0 when i_rs1x0, o_rs2 = 0 when i_rs2x0, else captured values.
REQ-014 Head fields SHALL drive o_* and h_* combinationally from the read pointer; o_itag = oitf_ptr.
REQ-015 Head "serialising" = grp CSR (3'd3) or (grp BJP (3'd1) & fence); "longp-predicted" = grp AGU (3'd2).
REQ-016 o_valid SHALL = count!=0 & state==RUN & !dep & !(serialising & !oitf_empty) & !(longp-predicted & !oitf_ready).
REQ-017 oitf_ena SHALL = o_valid & o_ready & o_longpipe.
REQ-018 FSM states RUN, DRAIN, HPEND, HALT; reset state RUN.
REQ-019 RUN->DRAIN when head serialising & !oitf_empty & no WFI request; DRAIN->RUN when oitf_empty.
REQ-020 RUN or DRAIN ->HPEND when wfi_halt_req & no pop this cycle; WFI request takes priority over DRAIN entry.
REQ-021 HPEND->HALT when oitf_empty & !amo_wait; HPEND/HALT->RUN when wfi_halt_req deasserts.
REQ-022 wfi_halt_ack SHALL be registered, 1 exactly while state==HALT.
REQ-023 No pop SHALL occur in DRAIN, HPEND or HALT; pushes continue while not full.
REQ-024 stall_cnt SHALL increment by 1 each cycle count!=0 and no pop occurs, saturating at 16'hFFFF.

Reset
REQ-025 On rst sampled high at posedge clk: pointers, count, stall_cnt = 0; state RUN; wfi_halt_ack = 0; storage contents undefined.
REQ-026 Reset mid-operation SHALL discard all buffered entries; o_valid = 0 and i_ready = 1 in the first cycle after reset.

Structure
REQ-027 Group codes, FSM state encoding and default parameter constants SHALL live in shared package e203_disp_pkg.
REQ-028 FIFO storage/pointers SHALL be one sub-module e203_disp_fifo; FSM, qualification and counter stay in the top.

Verification
REQ-029 DEPTH=2: push A,B with o_ready=0 -> i_ready=0 after B; raise o_ready, push C simultaneously with pop -> order A,B,C, count never exceeds 2.
REQ-030 Head grp=3 (CSR), oitf_empty=0 for 3 cycles -> state DRAIN, o_valid=0, stall_cnt=3; oitf_empty=1 -> RUN, o_valid=1 next cycle.
REQ-031 wfi_halt_req=1, amo_wait=1, oitf_empty=1 -> HPEND, ack=0; amo_wait=0 -> ack=1 next cycle; req=0 -> RUN, ack=0.
REQ-032 Head grp=2, oitf_ready=0 -> o_valid=0; oitf_ready=1, o_ready=1, o_longpipe=1 -> oitf_ena=1 for one cycle, o_itag=oitf_ptr.
REQ-033 i_rs1x0=1, i_rs1=32'hDEADBEEF -> o_rs1=0; dep=1 holds o_valid=0 until dep=0.
REQ-034 Force stall 70000 cycles -> stall_cnt stays 16'hFFFF; assert rst mid-stall -> count=0, stall_cnt=0, o_valid=0 next cycle.
